// File: rtl/lsu_if.sv
// Data-memory port between the load/store unit (master) and data memory (slave).
// The master holds a request stable until ready is seen; rdata is valid with ready on loads.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: one byte/half/word access per start over a req/ready memory port,
// with lane placement for stores, sign/zero extension for loads and misalignment detection.
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    lsu_if.master             bus
);
    typedef enum logic [1:0] {IDLE, MEM, FIN} state_t;

    state_t      state, state_n;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        err_q;
    logic        legal, accept, reject, complete;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [15:0] low16;
    logic [31:0] load_ext;

    // Width/sign encodings that exist for the direction, then natural alignment for that width.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'd0:    legal = 1'b1;
            3'd1:    legal = ~addr[0];
            3'd2:    legal = (addr[1:0] == 2'b00);
            3'd4:    legal = ~is_store;
            3'd5:    legal = ~is_store & ~addr[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        lane_wdata = store_data;
        lane_wmask = 4'b1111;
        case (funct3[1:0])
            2'd0: begin
                lane_wdata = {4{store_data[7:0]}};
                lane_wmask = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                lane_wdata = {2{store_data[15:0]}};
                lane_wmask = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Byte and halfword loads only ever need the low 16 bits after lane alignment.
    assign low16 = 16'(bus.mem_rdata >> {off_q, 3'b000});

    always_comb begin
        case (funct3_q)
            3'd0:    load_ext = {{24{low16[7]}}, low16[7:0]};
            3'd1:    load_ext = {{16{low16[15]}}, low16};
            3'd4:    load_ext = {24'd0, low16[7:0]};
            3'd5:    load_ext = {16'd0, low16};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        reject   = 1'b0;
        complete = 1'b0;
        busy     = (state != IDLE);
        done     = (state == FIN);
        err      = (state == FIN) & err_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal) begin
                        accept  = 1'b1;
                        state_n = MEM;
                    end else begin
                        reject  = 1'b1;
                        state_n = FIN;
                    end
                end
            end
            MEM: begin
                if (bus.mem_ready) begin
                    complete = 1'b1;
                    state_n  = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Memory-side outputs come straight from registers so they stay stable through wait states.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_store_q    <= 1'b0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            err_q         <= 1'b0;
            load_data     <= 32'd0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= 32'd0;
            bus.mem_wmask <= 4'd0;
        end else begin
            if (accept || reject) begin
                is_store_q <= is_store;
                funct3_q   <= funct3;
                off_q      <= addr[1:0];
                err_q      <= reject;
            end
            if (accept) begin
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= is_store;
                bus.mem_addr  <= addr & ~ADDR_W'(3);
                bus.mem_wdata <= is_store ? lane_wdata : 32'd0;
                bus.mem_wmask <= is_store ? lane_wmask : 4'd0;
            end
            if (complete) begin
                bus.mem_req <= 1'b0;
                if (!is_store_q) load_data <= load_ext;
            end
        end
    end
endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit in the execute/memory stage, directly downstream of the ALU.
- Takes the ALU result (rs1 + imm) as the effective address and performs one RV32I load or store over a simple req/ready data-memory port.
- Returns aligned, sign- or zero-extended load data with a single-cycle done pulse.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
ADDR_W, 32, width of addr and mem_addr (2..32).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  request a memory op; sampled only when busy=0
is_store  in  1  1=store, 0=load
funct3  in  3  RV32I width/sign: LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2
addr  in  ADDR_W  effective address (ALU dout)
store_data  in  32  rs2 value
busy  out  1  op in flight; start ignored
done  out  1  one-cycle pulse, op complete
err  out  1  valid with done: misaligned or illegal funct3
load_data  out  32  valid with done for loads; held until next done
mem_req  out  1  memory request
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte enables; 0 for loads
mem_ready  in  1  memory accepts/completes op this cycle
mem_rdata  in  32  read word, valid when mem_ready=1 on a load

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and reset.
- Reset values: busy=0, done=0, err=0, load_data=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0; FSM=IDLE.
- FSM states: IDLE, MEM, FIN.
- IDLE, start=1, access legal: capture is_store, funct3, addr[1:0]; drive all mem_* outputs from registers; mem_req=1; busy=1; go to MEM.
- IDLE, start=1, access illegal: capture request; go to FIN with err pending; mem_req stays 0.
- Illegal conditions:
  - load funct3 in {3,6,7}; store funct3 >= 3;
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0.
- MEM:
  - Hold mem_req=1 and all mem_* outputs stable until mem_ready=1 is sampled.
  - On that edge: mem_req=0; for loads, register the extracted load_data; go to FIN.
  - No timeout.
- FIN: done=1, err as determined, busy=1 for this cycle; return to IDLE. Next start is accepted the cycle after done.
- Latency:
  - Start sampled at edge 0 gives mem_req high in cycle 1.
  - Ready sampled at edge k gives done high in cycle k+1.
  - Minimum latency: done in cycle 2 after start.
  - Illegal access: done+err in cycle 1, no mem_req.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wmask=addr[1]?4'b1100:4'b0011.
  - SW: wdata=sd, wmask=4'b1111.
  - mem_we=1.
- Load extract:
  - Shift mem_rdata right by 8*addr[1:0], then apply funct3.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW takes the word unshifted.
  - mem_we=0, mem_wmask=0.
- Held values:
  - load_data changes only on a completed, legal load.
  - Stores and errored ops leave load_data unchanged.
- start while busy=1 is ignored; no queueing.
- mem_ready while mem_req=0 is ignored.
- Reset mid-op (MEM or FIN): next cycle is IDLE with all outputs at reset values. A pending mem_ready after reset is ignored. No done pulse.
- done and err are never asserted outside FIN.

Test Plan:
- Load LW, addr=0x100, mem_rdata=0xDEADBEEF, mem_ready tied 1 -> mem_req cycle 1 with mem_addr=0x100, mem_we=0; done cycle 2; load_data=0xDEADBEEF; err=0.
- Load LB/LBU, addr=0x103, mem_rdata=0x80FF1234 -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr=0x102 on the same word gives 0xFFFF80FF; LHU gives 0x000080FF.
- Store SB addr=0x202 sd=0x11223344 -> mem_addr=0x200, wdata=0x44444444, wmask=0100, we=1. SH addr=0x202 -> wdata=0x33443344, wmask=1100.
- Wait states: mem_ready low for 3 cycles after mem_req -> mem_req and mem_* outputs stable for all 4 cycles. done exactly one cycle after ready. A second start during busy is ignored: exactly one mem_req phase is seen.
- Errors: LW addr=0x102, SH addr=0x201, load funct3=3 -> no mem_req; done+err in cycle after start; load_data keeps its prior value.
- Reset asserted in MEM while mem_req=1 -> next cycle mem_req=0, busy=0, no done. A following LW completes normally.
